// File: rtl/l2_arbiter_pkg.sv
// Shared LC-3b memory-hierarchy types, including the L2 arbiter state and side encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } lc3b_arb_side;

endpackage

// File: rtl/l2_arbiter_control.sv
// L2 arbiter control: grant selection, serve FSM, last-grant tracking and response steering.
module l2_arbiter_control
  import lc3b_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_i_req,
  input  logic          i_d_req,
  input  logic          i_l2_resp,
  output logic          o_grant_i,
  output logic          o_grant_d,
  output logic          o_icache_resp,
  output logic          o_dcache_resp,
  output lc3b_arb_state o_state
);

  lc3b_arb_state r_state;
  lc3b_arb_side  r_last_grant;
  logic          w_pick_d;

  // With both sides pending, fair mode hands the grant to whoever did not win last.
  always_comb begin
    w_pick_d = i_d_req;
    if (i_d_req && i_i_req) begin
      w_pick_d = FAIR ? (r_last_grant == GRANT_I) : 1'b1;
    end
  end

  assign o_grant_d = (r_state == IDLE) && i_d_req && w_pick_d;
  assign o_grant_i = (r_state == IDLE) && i_i_req && !w_pick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_grant_d) begin
            r_state      <= SERVE_D;
            r_last_grant <= GRANT_D;
          end else if (o_grant_i) begin
            r_state      <= SERVE_I;
            r_last_grant <= GRANT_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (i_l2_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Responses pass straight through in the L2 resp cycle; an L2 resp seen in IDLE is dropped.
  assign o_icache_resp = (r_state == SERVE_I) && i_l2_resp;
  assign o_dcache_resp = (r_state == SERVE_D) && i_l2_resp;
  assign o_state       = r_state;

endmodule

// File: rtl/l2_arbiter.sv
// Two-port L1-to-L2 arbiter: latches the granted command and holds it on the L2 port until resp.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  lc3b_word       icache_pmem_address,
  input  logic           icache_pmem_read,
  output lc3b_cache_line icache_pmem_rdata,
  output logic           icache_pmem_resp,
  input  lc3b_word       dcache_pmem_address,
  input  logic           dcache_pmem_read,
  input  logic           dcache_pmem_write,
  input  lc3b_cache_line dcache_pmem_wdata,
  output lc3b_cache_line dcache_pmem_rdata,
  output logic           dcache_pmem_resp,
  output lc3b_word       l2arb_mem_address,
  output logic           l2arb_mem_read,
  output logic           l2arb_mem_write,
  output lc3b_cache_line l2arb_mem_wdata,
  input  lc3b_cache_line l2arb_mem_rdata,
  input  logic           l2arb_mem_resp,
  output lc3b_arb_state  o_dbg_state
);

  logic           w_grant_i;
  logic           w_grant_d;
  logic           w_serving;
  lc3b_word       r_addr;
  logic           r_read;
  logic           r_write;
  lc3b_cache_line r_wdata;

  l2_arbiter_control #(
    .FAIR(FAIR)
  ) u_control (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_i_req       (icache_pmem_read),
    .i_d_req       (dcache_pmem_read | dcache_pmem_write),
    .i_l2_resp     (l2arb_mem_resp),
    .o_grant_i     (w_grant_i),
    .o_grant_d     (w_grant_d),
    .o_icache_resp (icache_pmem_resp),
    .o_dcache_resp (dcache_pmem_resp),
    .o_state       (o_dbg_state)
  );

  assign w_serving = (o_dbg_state != IDLE);

  // A D-side read+write request is illegal; the write wins and the read is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant_d) begin
      r_addr  <= dcache_pmem_address;
      r_read  <= dcache_pmem_read & ~dcache_pmem_write;
      r_write <= dcache_pmem_write;
      r_wdata <= dcache_pmem_wdata;
    end else if (w_grant_i) begin
      r_addr  <= icache_pmem_address;
      r_read  <= 1'b1;
      r_write <= 1'b0;
    end else if (w_serving && l2arb_mem_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  assign l2arb_mem_address = r_addr;
  assign l2arb_mem_read    = r_read;
  assign l2arb_mem_write   = r_write;
  assign l2arb_mem_wdata   = r_wdata;

  assign icache_pmem_rdata = l2arb_mem_rdata;
  assign dcache_pmem_rdata = l2arb_mem_rdata;

endmodule
